icc_branch_unit: RTL

- Consumer end of the SPARC ALU flag interface.
- Holds the integer condition codes (icc: N,Z,V,C) written by S-suffix ALU ops and feeds the C bit back as the ALU carry input.
- Evaluates Bicc conditions and sequences the delayed-branch delay slot, including annul.
- Issues a single-cycle PC redirect to fetch.

---
 rtl/icc_branch_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/icc_branch_unit.sv
// SPARC icc holder, Bicc evaluator and delay-slot/annul sequencer with one-cycle PC redirect.
// Optional macro CC_BYPASS_EN: evaluate branches against forwarded flags instead of stalling.
module icc_branch_unit #(
  parameter int unsigned ADDR_W    = 32,
  parameter logic [3:0]  RESET_ICC = 4'b0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cc_we,
  input  logic              n_in,
  input  logic              z_in,
  input  logic              v_in,
  input  logic              c_in,
  input  logic              icc_wr_en,
  input  logic [3:0]        icc_wr_data,
  input  logic              br_valid,
  input  logic [3:0]        br_cond,
  input  logic              br_annul,
  input  logic [ADDR_W-1:0] br_target,
  output logic              br_ready,
  input  logic              slot_issue,
  input  logic              flush,
  output logic              annul_slot,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [3:0]        icc,
  output logic              carry_out
);

  typedef enum logic [1:0] {IDLE, SLOT, REDIRECT} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_icc;
  logic [3:0]          w_icc_next;
  logic [3:0]          w_eval;
  logic                w_cc_stall;
  logic                w_cond_raw;
  logic                w_taken;
  logic                w_annul;
  logic                w_accept;
  logic                r_taken;
  logic                r_annul;
  logic [ADDR_W-1:0]   r_target;

  always_comb begin
    w_icc_next = r_icc;
    if (icc_wr_en)  w_icc_next = icc_wr_data;
    else if (cc_we) w_icc_next = {n_in, z_in, v_in, c_in};
  end

`ifdef CC_BYPASS_EN
  assign w_eval     = w_icc_next;
  assign w_cc_stall = 1'b0;
`else
  assign w_eval     = r_icc;
  assign w_cc_stall = cc_we | icc_wr_en;
`endif

  // w_eval = {N,Z,V,C}; cond[3] inverts the base test selected by cond[2:0]
  always_comb begin
    w_cond_raw = 1'b0;
    unique case (br_cond[2:0])
      3'b000: w_cond_raw = 1'b0;
      3'b001: w_cond_raw = w_eval[2];
      3'b010: w_cond_raw = w_eval[2] | (w_eval[3] ^ w_eval[1]);
      3'b011: w_cond_raw = w_eval[3] ^ w_eval[1];
      3'b100: w_cond_raw = w_eval[0] | w_eval[2];
      3'b101: w_cond_raw = w_eval[0];
      3'b110: w_cond_raw = w_eval[3];
      3'b111: w_cond_raw = w_eval[1];
      default: w_cond_raw = 1'b0;
    endcase
  end

  assign w_taken = br_cond[3] ^ w_cond_raw;
  assign w_annul = br_annul & (~w_taken | (br_cond == 4'b1000));

  always_comb begin
    w_next         = r_state;
    w_accept       = 1'b0;
    br_ready       = 1'b0;
    annul_slot     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    unique case (r_state)
      IDLE: begin
        br_ready = ~w_cc_stall;
        if (br_valid && !w_cc_stall) begin
          w_accept = 1'b1;
          w_next   = SLOT;
        end
      end
      SLOT: begin
        annul_slot = r_annul;
        if (slot_issue) w_next = r_taken ? REDIRECT : IDLE;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = r_target;
        w_next         = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // flush overrides the transition only; a REDIRECT pulse already on the outputs stays
    if (flush) w_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_icc    <= RESET_ICC;
      r_taken  <= 1'b0;
      r_annul  <= 1'b0;
      r_target <= '0;
    end else begin
      r_state <= w_next;
      r_icc   <= w_icc_next;
      if (flush) begin
        r_taken  <= 1'b0;
        r_annul  <= 1'b0;
        r_target <= '0;
      end else if (w_accept) begin
        r_taken  <= w_taken;
        r_annul  <= w_annul;
        r_target <= br_target;
      end
    end
  end

  assign icc       = r_icc;
  assign carry_out = r_icc[0];

endmodule
